seq_signed_divider: RTL and testbench

- Iterative restoring divider for the multicycle CPU's DIV instruction; one quotient bit per cycle.
- Sits between the A/B operand registers and the Hi/Lo source muxes.
- Dividend is taken from A and divisor from B. The quotient feeds the Lo mux input and the remainder feeds the Hi mux input.
- The control unit pulses start and waits for done before writing Hi/Lo; dzero raises the divide-by-zero exception.

---
 rtl/seq_signed_divider.sv | 132 +++++++++++++
 tb/tb_seq_signed_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative restoring signed divider (MIPS DIV semantics)
// Optional macro SEQ_DIVIDER_UNSIGNED_EN adds is_unsigned for DIVU support.
module seq_signed_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dzero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] rem, rem_nx, quo, quo_nx, dvs, dvs_nx;
  logic [WIDTH-1:0] quotient_nx, remainder_nx;
  logic             sign_q, sign_q_nx, sign_r, sign_r_nx;
  logic             busy_nx, done_nx, dzero_nx;
  logic             uns;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Magnitudes wrap naturally: the most negative value maps onto itself as unsigned.
  assign abs_a   = (!uns && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b   = (!uns && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dzero     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rem       <= rem_nx;
      quo       <= quo_nx;
      dvs       <= dvs_nx;
      sign_q    <= sign_q_nx;
      sign_r    <= sign_r_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      dzero     <= dzero_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    rem_nx       = rem;
    quo_nx       = quo;
    dvs_nx       = dvs;
    sign_q_nx    = sign_q;
    sign_r_nx    = sign_r;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    busy_nx      = busy;
    done_nx      = 1'b0;
    dzero_nx     = dzero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dzero_nx = 1'b1;
            done_nx  = 1'b1;
          end else begin
            dzero_nx  = 1'b0;
            sign_q_nx = !uns && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_nx = !uns && dividend[WIDTH-1];
            quo_nx    = abs_a;
            dvs_nx    = abs_b;
            rem_nx    = '0;
            cnt_nx    = '0;
            busy_nx   = 1'b1;
            state_nx  = RUN;
          end
        end
      end
      RUN: begin
        // A negative trial implies shifted < dvs, so its top bit is already zero.
        if (!trial[WIDTH]) begin
          rem_nx = trial[WIDTH-1:0];
          quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_nx = shifted[WIDTH-1:0];
          quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        quotient_nx  = sign_q ? -quo : quo;
        remainder_nx = sign_r ? -rem : rem;
        done_nx      = 1'b1;
        busy_nx      = 1'b0;
        state_nx     = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - self-checking bench for seq_signed_divider
// Define SEQ_DIVIDER_UNSIGNED_EN to exercise the unsigned mode as well.
module tb_seq_signed_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_uns;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, dzero;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
    .is_unsigned(is_uns),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dzero     (dzero)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: 64-bit arithmetic truncates toward zero and gives the remainder the dividend's sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit u,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (u) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = W'(sa / sb);
    r = W'(sa % sb);
  endfunction

  // poke >= 0 fires a start with 5/5 at that cycle of the run; it must be ignored.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit u, input int poke);
    int   n;
    logic busy_ok;
    @(posedge clk); #1;
    dividend = a; divisor = b; is_uns = u; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_uns = $urandom_range(0, 1);
    if (b == '0) begin
      chk({tag, "_dz_dzero"}, W'(dzero), W'(1));
      chk({tag, "_dz_done"},  W'(done),  W'(1));
      chk({tag, "_dz_busy"},  W'(busy),  W'(0));
      chk({tag, "_dz_q"},     quotient,  exp_q);
      chk({tag, "_dz_r"},     remainder, exp_r);
      @(posedge clk); #1;
      chk({tag, "_dz_done_low"},  W'(done),  W'(0));
      chk({tag, "_dz_sticky"},    W'(dzero), W'(1));
    end else begin
      model(a, b, u, exp_q, exp_r);
      chk({tag, "_busy_start"},  W'(busy),  W'(1));
      chk({tag, "_dzero_clear"}, W'(dzero), W'(0));
      n = 0;
      busy_ok = 1'b1;
      while (!done && n < 100) begin
        @(posedge clk); #1;
        n++;
        if (n == poke) begin
          start = 1'b1; dividend = 5; divisor = 5;
        end else begin
          start = 1'b0;
        end
        if (!done && !busy) busy_ok = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_latency"},   W'(n),       W'(W + 1));
      chk({tag, "_busy_held"}, W'(busy_ok), W'(1));
      chk({tag, "_busy_end"},  W'(busy),    W'(0));
      chk({tag, "_q"},         quotient,    exp_q);
      chk({tag, "_r"},         remainder,   exp_r);
      @(posedge clk); #1;
      chk({tag, "_done_low"},  W'(done),    W'(0));
      chk({tag, "_q_hold"},    quotient,    exp_q);
    end
  endtask

  initial begin
    int   n;
    logic saw_done;
    reset = 1'b0; start = 1'b0; is_uns = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_dzero", W'(dzero), W'(0));
    reset = 1'b1;

    run_div("d7_2",     32'd7,          32'd2,          1'b0, -1);
    run_div("dm7_2",    32'hFFFF_FFF9,  32'd2,          1'b0, -1);
    run_div("d7_m2",    32'd7,          32'hFFFF_FFFE,  1'b0, -1);
    run_div("ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b0, -1);
    run_div("d100_10",  32'd100,        32'd10,         1'b0, -1);
    run_div("d7_2b",    32'd7,          32'd2,          1'b0, -1);
    run_div("div0",     32'd55,         32'd0,          1'b0, -1);
    run_div("after0",   32'd100,        32'd10,         1'b0, -1);
    run_div("d1000_7",  32'd1000,       32'd7,          1'b0, 5);
    run_div("min_min",  32'h8000_0000,  32'h8000_0000,  1'b0, -1);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = $urandom_range(1, 20);
      if (i % 4 == 1) b = -$urandom_range(1, 20);
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      run_div("rnd", a, b, 1'($urandom_range(0, 1)), -1);
`else
      run_div("rnd", a, b, 1'b0, -1);
`endif
    end

`ifdef SEQ_DIVIDER_UNSIGNED_EN
    run_div("divu",     32'hFFFF_FFFE,  32'd2,          1'b1, -1);
    run_div("divs",     32'hFFFF_FFFE,  32'd2,          1'b0, -1);
    run_div("divu0",    32'hFFFF_FFFE,  32'd0,          1'b1, -1);
`endif

    // Abort a run mid-flight with an asynchronous reset.
    @(posedge clk); #1;
    dividend = 32'd1000; divisor = 32'd3; is_uns = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_q", quotient, '0);
    chk("abort_r", remainder, '0);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    saw_done = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", W'(saw_done), W'(0));
    chk("abort_q_idle", quotient, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
